// File: rtl/avl_data_sram_if.sv
// Avalon-MM data-master bus bundle between a core data master and the SRAM slave.
interface avl_data_sram_if;
  logic [31:0] avl_address;
  logic [3:0]  avl_byteenable;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;

  modport master (
    output avl_address, avl_byteenable, avl_read, avl_write, avl_writedata,
    input  avl_readdata, avl_waitrequest
  );

  modport slave (
    input  avl_address, avl_byteenable, avl_read, avl_write, avl_writedata,
    output avl_readdata, avl_waitrequest
  );
endinterface

// File: rtl/avl_data_sram.sv
// Avalon-MM word SRAM with programmable wait states and byte-lane writes.
// Optional AVL_SRAM_BUS_ERR_EN: out-of-range accesses are rejected and flagged on mem_err.
module avl_data_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            reset,
  avl_data_sram_if.slave  avl,
  output logic            mem_err
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_nxt;
  logic [AW-1:0] r_idx;
  logic          r_in_range;
  logic          r_write;
  logic          r_read;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   r_readdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx_in;
  logic          w_in_range_in;
  logic          w_latch;
  logic [AW-1:0] w_rd_idx;
  logic          w_rd_en;
  logic          w_rd_ok;
  logic          w_wr_ok;
  logic          w_unused;

  assign w_req         = avl.avl_read | avl.avl_write;
  assign w_off         = avl.avl_address - BASE_ADDR;
  assign w_idx_in      = w_off[AW+1:2];
  // Offset subtraction wraps, so addresses below BASE_ADDR also land out of range.
  assign w_in_range_in = (w_off[31:AW+2] == {(30-AW){1'b0}});
  assign w_latch       = (r_state == ST_IDLE) && w_req;

  // With zero wait states ACK is entered straight from IDLE, before anything is latched.
  assign w_rd_idx = (r_state == ST_IDLE) ? w_idx_in : r_idx;
  assign w_rd_en  = (r_state == ST_IDLE) ? (avl.avl_read & ~avl.avl_write) : r_read;
  assign w_rd_ok  = (r_state == ST_IDLE) ? w_in_range_in : r_in_range;

  assign avl.avl_waitrequest = w_req & (r_state != ST_ACK);
  assign avl.avl_readdata    = r_readdata;

`ifdef AVL_SRAM_BUS_ERR_EN
  logic r_mem_err;
  assign w_wr_ok  = r_in_range;
  assign mem_err  = r_mem_err;
  assign w_unused = ^{w_off[1:0]};
`else
  assign w_wr_ok  = 1'b1;
  assign mem_err  = 1'b0;
  assign w_unused = ^{w_off[1:0], w_off[31:AW+2], w_rd_ok, r_in_range};
`endif

  // Next-state and wait counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (WAIT_STATES > 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WS_LOAD;
          end else begin
            w_state_nxt = ST_ACK;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
        end else if (r_cnt == 3'd0) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State register and request capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_idx      <= {AW{1'b0}};
      r_in_range <= 1'b0;
      r_write    <= 1'b0;
      r_read     <= 1'b0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_idx      <= w_idx_in;
        r_in_range <= w_in_range_in;
        r_write    <= avl.avl_write;
        r_read     <= avl.avl_read & ~avl.avl_write;
        r_be       <= avl.avl_byteenable;
        r_wdata    <= avl.avl_writedata;
      end
    end
  end

  // Read data capture on entry to ACK
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_readdata <= 32'h0;
    end else if ((w_state_nxt == ST_ACK) && w_rd_en) begin
`ifdef AVL_SRAM_BUS_ERR_EN
      r_readdata <= w_rd_ok ? r_mem[w_rd_idx] : 32'hDEAD_BEEF;
`else
      r_readdata <= r_mem[w_rd_idx];
`endif
    end
  end

`ifdef AVL_SRAM_BUS_ERR_EN
  // Sticky out-of-range flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem_err <= 1'b0;
    end else if ((w_state_nxt == ST_ACK) && !w_rd_ok) begin
      r_mem_err <= 1'b1;
    end
  end
`endif

  // Byte-lane write commit at the edge that ends ACK; array is never reset
  always_ff @(posedge clk) begin
    if (reset && (r_state == ST_ACK) && r_write && w_wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_avl_data_sram.sv
// Directed bench: one SRAM with one wait state and one with none, checked task by task.
module tb_avl_data_sram;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  avl_data_sram_if bus1();
  avl_data_sram_if bus0();
  logic err1;
  logic err0;

  avl_data_sram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset(reset), .avl(bus1), .mem_err(err1)
  );
  avl_data_sram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .avl(bus0), .mem_err(err0)
  );

  int checks = 0;
  int errors = 0;

  task automatic drive(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
    if (sel) begin
      bus1.avl_read = rd; bus1.avl_write = wr; bus1.avl_address = addr;
      bus1.avl_byteenable = be; bus1.avl_writedata = data;
    end else begin
      bus0.avl_read = rd; bus0.avl_write = wr; bus0.avl_address = addr;
      bus0.avl_byteenable = be; bus0.avl_writedata = data;
    end
  endtask

  function automatic logic get_wait(input bit sel);
    return sel ? bus1.avl_waitrequest : bus0.avl_waitrequest;
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? bus1.avl_readdata : bus0.avl_readdata;
  endfunction

  // One complete transfer; returns cycles of waitrequest high and readdata seen in ACK.
  task automatic xfer(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] data,
                      output int hi, output logic [31:0] rdata);
    bit done;
    @(negedge clk);
    drive(sel, rd, wr, addr, be, data);
    hi = 0; done = 1'b0; rdata = 32'h0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (!get_wait(sel)) begin
        done = 1'b1;
        rdata = get_rdata(sel);
      end else begin
        hi++;
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout: addr=%h still waiting after 20 cycles, required ack", addr);
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus1.avl_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h want %h", bus1.avl_readdata, 32'h0); end
    checks++; if (bus0.avl_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h want %h", bus0.avl_readdata, 32'h0); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err1); end
    checks++; if (bus1.avl_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", bus1.avl_waitrequest); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int hi; logic [31:0] rd;
    xfer(1'b1, 1'b0, 1'b1, 32'h10, 4'hF, 32'h1122_3344, hi, rd);
    checks++; if (hi !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", hi); end
    xfer(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, hi, rd);
    checks++; if (hi !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", hi); end
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL rd_data: got %h want %h", rd, 32'h1122_3344); end
  endtask

  task automatic test_byteenable;
    int hi; logic [31:0] rd;
    xfer(1'b1, 1'b0, 1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD, hi, rd);
    xfer(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, hi, rd);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL be_merge: got %h want %h", rd, 32'h11BB_33DD); end
    xfer(1'b1, 1'b1, 1'b0, 32'h13, 4'hF, 32'h0, hi, rd);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL addr_lsb: got %h want %h", rd, 32'h11BB_33DD); end
    xfer(1'b1, 1'b0, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, hi, rd);
    checks++; if (hi !== 2) begin errors++; $display("FAIL be0_latency: got %0d want 2", hi); end
    xfer(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, hi, rd);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL be0_nochange: got %h want %h", rd, 32'h11BB_33DD); end
  endtask

  task automatic test_rw_both;
    int hi; logic [31:0] rd;
    xfer(1'b1, 1'b1, 1'b1, 32'h30, 4'hF, 32'h5, hi, rd);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL rw_rdata_kept: got %h want %h", rd, 32'h11BB_33DD); end
    xfer(1'b1, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0, hi, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL rw_written: got %h want %h", rd, 32'h5); end
  endtask

  task automatic test_back_to_back;
    int hi; logic [31:0] rd;
    logic exp_w [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_d [3] = '{32'hA0A0_A0A0, 32'hB4B4_B4B4, 32'hC8C8_C8C8};
    xfer(1'b0, 1'b0, 1'b1, 32'h0, 4'hF, 32'hA0A0_A0A0, hi, rd);
    checks++; if (hi !== 1) begin errors++; $display("FAIL ws0_latency: got %0d want 1", hi); end
    xfer(1'b0, 1'b0, 1'b1, 32'h4, 4'hF, 32'hB4B4_B4B4, hi, rd);
    xfer(1'b0, 1'b0, 1'b1, 32'h8, 4'hF, 32'hC8C8_C8C8, hi, rd);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (bus0.avl_waitrequest !== exp_w[k]) begin
        errors++; $display("FAIL b2b_wait[%0d]: got %b want %b", k, bus0.avl_waitrequest, exp_w[k]);
      end
      if (k % 2 == 1) begin
        checks++;
        if (bus0.avl_readdata !== exp_d[k/2]) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k/2, bus0.avl_readdata, exp_d[k/2]);
        end
        if (k < 5) drive(1'b0, 1'b1, 1'b0, 32'(4 * (k/2 + 1)), 4'hF, 32'h0);
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic test_drop_wait;
    int hi; logic [31:0] rd;
    xfer(1'b1, 1'b0, 1'b1, 32'h40, 4'hF, 32'h0101_0101, hi, rd);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h40, 4'hF, 32'hCAFE_F00D);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checks++; if (bus1.avl_waitrequest !== 1'b0) begin errors++; $display("FAIL drop_wait: got %b want 0", bus1.avl_waitrequest); end
    @(negedge clk);
    xfer(1'b1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, hi, rd);
    checks++; if (rd !== 32'h0101_0101) begin errors++; $display("FAIL drop_nowrite: got %h want %h", rd, 32'h0101_0101); end
  endtask

  task automatic test_ignore_changes;
    int hi; logic [31:0] rd;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h40, 4'hF, 32'h7777_7777);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h44, 4'h0, 32'h0);
    @(negedge clk);
    #1;
    checks++; if (bus1.avl_waitrequest !== 1'b0) begin errors++; $display("FAIL chg_ack: got %b want 0", bus1.avl_waitrequest); end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    xfer(1'b1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, hi, rd);
    checks++; if (rd !== 32'h7777_7777) begin errors++; $display("FAIL chg_latched: got %h want %h", rd, 32'h7777_7777); end
  endtask

  task automatic test_reset_midway;
    int hi; logic [31:0] rd;
    xfer(1'b1, 1'b0, 1'b1, 32'h20, 4'hF, 32'h1234_5678, hi, rd);
    xfer(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, hi, rd);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus1.avl_readdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h want %h", bus1.avl_readdata, 32'h0); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err1); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    xfer(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, hi, rd);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL midrst_nowrite: got %h want %h", rd, 32'h1234_5678); end
  endtask

  task automatic test_range;
    int hi; logic [31:0] rd;
    xfer(1'b1, 1'b0, 1'b1, 32'h0, 4'hF, 32'h00C0_FFEE, hi, rd);
`ifdef AVL_SRAM_BUS_ERR_EN
    xfer(1'b1, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, hi, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_rdata: got %h want %h", rd, 32'hDEAD_BEEF); end
    checks++; if (hi !== 2) begin errors++; $display("FAIL oor_latency: got %0d want 2", hi); end
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL oor_err_set: got %b want 1", err1); end
    xfer(1'b1, 1'b0, 1'b1, 32'h1000, 4'hF, 32'h0BAD_F00D, hi, rd);
    xfer(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, hi, rd);
    checks++; if (rd !== 32'h00C0_FFEE) begin errors++; $display("FAIL oor_wr_dropped: got %h want %h", rd, 32'h00C0_FFEE); end
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %b want 1", err1); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %b want 0", err1); end
`else
    xfer(1'b1, 1'b0, 1'b1, 32'h1000, 4'hF, 32'h0BAD_F00D, hi, rd);
    xfer(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, hi, rd);
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL alias_word0: got %h want %h", rd, 32'h0BAD_F00D); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL alias_err: got %b want 0", err1); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byteenable();
    test_rw_both();
    test_back_to_back();
    test_drop_wait();
    test_ignore_changes();
    test_reset_midway();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
